// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings, oversampling constants,
// and the transmitter state type that lives alongside them.
package uart_pkg;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'd15;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t RX_IDLE   = 3'd0;
  localparam rx_state_t RX_START  = 3'd1;
  localparam rx_state_t RX_DATA   = 3'd2;
  localparam rx_state_t RX_PARITY = 3'd3;
  localparam rx_state_t RX_STOP   = 3'd4;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; every stage
// resets to 1 so the receiver sees an idle line coming out of reset.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_reg <= '1;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x-oversampled start/data/parity/stop recovery with
// mid-bit sampling, one-cycle valid strobe and parity/framing error flags.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              baud_tick_16x,
  input  logic              rx,
  input  logic              parity_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  logic              rx_s;
  logic              rx_d_reg;

  rx_state_t         state_reg,      state_next;
  logic [SCNT_W-1:0] scnt_reg,       scnt_next;
  logic [BIT_W-1:0]  bcnt_reg,       bcnt_next;
  logic [DATA_W-1:0] shift_reg,      shift_next;
  logic              par_acc_reg,    par_acc_next;
  logic              par_en_reg,     par_en_next;
  logic              par_pend_reg,   par_pend_next;
  logic [DATA_W-1:0] rx_data_reg,    rx_data_next;
  logic              rx_valid_reg,   rx_valid_next;
  logic              parity_err_reg, parity_err_next;
  logic              frame_err_reg,  frame_err_next;

  uart_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  always_comb begin
    state_next      = state_reg;
    scnt_next       = scnt_reg;
    bcnt_next       = bcnt_reg;
    shift_next      = shift_reg;
    par_acc_next    = par_acc_reg;
    par_en_next     = par_en_reg;
    par_pend_next   = par_pend_reg;
    rx_data_next    = rx_data_reg;
    rx_valid_next   = 1'b0;
    parity_err_next = parity_err_reg;
    frame_err_next  = frame_err_reg;

    case (state_reg)
      RX_IDLE: begin
        // Falling edge only: a line stuck low must go high again first.
        if (rx_d_reg && !rx_s) begin
          scnt_next  = '0;
          state_next = RX_START;
        end
      end

      RX_START: begin
        if (baud_tick_16x) begin
          if (scnt_reg == MID_SAMPLE) begin
            if (!rx_s) begin
              scnt_next     = '0;
              bcnt_next     = '0;
              par_acc_next  = 1'b0;
              par_pend_next = 1'b0;
              par_en_next   = parity_en;
              state_next    = RX_DATA;
            end else begin
              state_next = RX_IDLE;
            end
          end else begin
            scnt_next = scnt_reg + 1'b1;
          end
        end
      end

      RX_DATA: begin
        if (baud_tick_16x) begin
          scnt_next = scnt_reg + 1'b1;
          if (scnt_reg == LAST_SAMPLE) begin
            shift_next   = {rx_s, shift_reg[DATA_W-1:1]};
            bcnt_next    = bcnt_reg + 1'b1;
            par_acc_next = par_acc_reg ^ rx_s;
            if (bcnt_reg == LAST_BIT) begin
              state_next = par_en_reg ? RX_PARITY : RX_STOP;
            end
          end
        end
      end

      RX_PARITY: begin
        if (baud_tick_16x) begin
          scnt_next = scnt_reg + 1'b1;
          if (scnt_reg == LAST_SAMPLE) begin
            par_pend_next = rx_s ^ par_acc_reg;
            state_next    = RX_STOP;
          end
        end
      end

      RX_STOP: begin
        // Leave at mid stop bit so a start edge right after it is caught.
        if (baud_tick_16x) begin
          scnt_next = scnt_reg + 1'b1;
          if (scnt_reg == LAST_SAMPLE) begin
            rx_data_next    = shift_reg;
            frame_err_next  = ~rx_s;
            parity_err_next = par_pend_reg;
            rx_valid_next   = 1'b1;
            scnt_next       = '0;
            state_next      = RX_IDLE;
          end
        end
      end

      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_d_reg       <= 1'b1;
      state_reg      <= RX_IDLE;
      scnt_reg       <= '0;
      bcnt_reg       <= '0;
      shift_reg      <= '0;
      par_acc_reg    <= 1'b0;
      par_en_reg     <= 1'b0;
      par_pend_reg   <= 1'b0;
      rx_data_reg    <= '0;
      rx_valid_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      rx_d_reg       <= rx_s;
      state_reg      <= state_next;
      scnt_reg       <= scnt_next;
      bcnt_reg       <= bcnt_next;
      shift_reg      <= shift_next;
      par_acc_reg    <= par_acc_next;
      par_en_reg     <= par_en_next;
      par_pend_reg   <= par_pend_next;
      rx_data_reg    <= rx_data_next;
      rx_valid_reg   <= rx_valid_next;
      parity_err_reg <= parity_err_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign busy       = (state_reg != RX_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: a serial driver pushes expected frames,
// an independent monitor pops and compares on every rx_valid strobe.
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk;
  logic       rst;
  logic       baud_tick_16x;
  logic       rx;
  logic       parity_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  uart_receiver #(
    .DATA_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick_16x (baud_tick_16x),
    .rx            (rx),
    .parity_en     (parity_en),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running 16x tick: one clk high out of every TICK_DIV.
  initial begin
    int cnt;
    cnt = 0;
    baud_tick_16x = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cnt = (cnt + 1) % TICK_DIV;
      baud_tick_16x = (cnt == 0);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b", name, act, req);
    end
  endtask

  // Drive one frame bit-serially; the expected result is derived from what
  // is put on the line: parity error iff the parity bit is not even parity.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pflip,
                            input logic stop_bit, input logic toggle_pen);
    exp_t e;
    logic pbit;
    pbit   = (^d) ^ pflip;
    e.data = d;
    e.perr = pen && (pbit != (^d));
    e.ferr = (stop_bit == 1'b0);
    exp_q.push_back(e);
    $display("tx frame data=%02h parity_en=%0b parity_bit=%0b stop=%0b", d, pen, pbit, stop_bit);
    parity_en = pen;
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      if (i == 0 && toggle_pen) parity_en = ~pen;
      rx = d[i];
      wait_clk(BIT_CLKS);
    end
    if (pen) begin
      rx = pbit;
      wait_clk(BIT_CLKS);
    end
    rx = stop_bit;
    wait_clk(BIT_CLKS);
    rx = 1'b1;
  endtask

  // Monitor: independent of stimulus, compares every strobe against the queue.
  initial begin
    logic       prev_valid;
    logic [7:0] held_data;
    logic       held_perr;
    logic       held_ferr;
    exp_t       e;
    prev_valid = 1'b0;
    held_data  = 8'h00;
    held_perr  = 1'b0;
    held_ferr  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        held_data  = 8'h00;
        held_perr  = 1'b0;
        held_ferr  = 1'b0;
      end else if (rx_valid) begin
        $display("rx frame data=%02h parity_err=%0b frame_err=%0b", rx_data, parity_err, frame_err);
        checks++;
        if (prev_valid) begin
          failures++;
          $display("FAIL valid_width actual=2+ cycles required=1 cycle");
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid actual=data %02h required=no frame", rx_data);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (rx_data !== e.data) begin
            failures++;
            $display("FAIL rx_data actual=%02h required=%02h", rx_data, e.data);
          end
          checks++;
          if (parity_err !== e.perr) begin
            failures++;
            $display("FAIL parity_err actual=%0b required=%0b (data %02h)", parity_err, e.perr, e.data);
          end
          checks++;
          if (frame_err !== e.ferr) begin
            failures++;
            $display("FAIL frame_err actual=%0b required=%0b (data %02h)", frame_err, e.ferr, e.data);
          end
        end
        held_data  = rx_data;
        held_perr  = parity_err;
        held_ferr  = frame_err;
        prev_valid = 1'b1;
      end else begin
        if (rx_data !== held_data || parity_err !== held_perr || frame_err !== held_ferr) begin
          checks++;
          failures++;
          $display("FAIL output_hold actual=%02h/%0b/%0b required=%02h/%0b/%0b",
                   rx_data, parity_err, frame_err, held_data, held_perr, held_ferr);
          held_data = rx_data;
          held_perr = parity_err;
          held_ferr = frame_err;
        end
        prev_valid = 1'b0;
      end
    end
  end

  initial begin
    int waited;
    rst       = 1'b1;
    rx        = 1'b1;
    parity_en = 1'b0;
    wait_clk(3);
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_rx_data actual=%02h required=00", rx_data);
    end
    check1("reset_rx_valid", rx_valid, 1'b0);
    check1("reset_parity_err", parity_err, 1'b0);
    check1("reset_frame_err", frame_err, 1'b0);
    check1("reset_busy", busy, 1'b0);
    rst = 1'b0;
    wait_clk(20);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clk(40);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_clk(40);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_clk(40);

    // Framing error, then the line stays low: must not re-trigger.
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    rx = 1'b0;
    wait_clk(3 * BIT_CLKS);
    check1("low_line_no_retrigger_busy", busy, 1'b0);
    rx = 1'b1;
    wait_clk(40);

    // Glitch of 3 ticks while idle.
    rx = 1'b0;
    wait_clk(8);
    check1("glitch_busy_during", busy, 1'b1);
    wait_clk(3 * TICK_DIV - 8);
    rx = 1'b1;
    wait_clk(BIT_CLKS);
    check1("glitch_busy_after", busy, 1'b0);

    // Back-to-back frames with a single stop bit.
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clk(40);

    // Reset during data bit 4: partial frame discarded.
    parity_en = 1'b0;
    rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_clk(BIT_CLKS);
    end
    rx = 1'b1;
    wait_clk(BIT_CLKS / 2);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_data !== 8'h00) begin
      failures++;
      $display("FAIL midreset_rx_data actual=%02h required=00", rx_data);
    end
    check1("midreset_busy", busy, 1'b0);
    check1("midreset_rx_valid", rx_valid, 1'b0);
    check1("midreset_flags", parity_err | frame_err, 1'b0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(BIT_CLKS);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_clk(40);

    // Randomized frames with random parity, corruption, stop errors, gaps.
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic pen, pflip, stop_bit, tog;
      d        = 8'($urandom_range(0, 255));
      pen      = 1'($urandom_range(0, 1));
      pflip    = pen & ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 7) != 0);
      tog      = 1'($urandom_range(0, 1));
      send_frame(d, pen, pflip, stop_bit, tog);
      if (!stop_bit) wait_clk(8 + $urandom_range(0, 40));
      else           wait_clk($urandom_range(0, 80));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      wait_clk(1);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL frames_outstanding actual=%0d required=0", exp_q.size());
    end
    wait_clk(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
